// File: rtl/la_orn_pipe_if.sv
// Bundle of the OR-reduction aggregator's control, event and result signals.
// Latency: none, wiring only.
// Backpressure: none; the aggregator always accepts its inputs, en is the only stall.
interface la_orn_pipe_if #(
   parameter int N = 4
);
   logic         en;
   logic [N-1:0] in;
   logic [N-1:0] mask;
   logic         clr;
   logic         z;
   logic         rise;
   logic [N-1:0] status;

   modport master (
      output en, in, mask, clr,
      input  z, rise, status
   );

   modport slave (
      input  en, in, mask, clr,
      output z, rise, status
   );
endinterface

// File: rtl/la_orn_pipe.sv
// Masked, optionally sticky, pipelined N-input OR reduction with a rising-edge pulse.
// Latency: STAGES register stages from in to z (status to z is STAGES-1 in sticky mode).
// Backpressure: none; en=0 freezes every register, including status and the edge history.
module la_orn_pipe #(
   parameter int N      = 4,
   parameter int STAGES = 1,
   parameter int STICKY = 0,
   parameter     PROP   = "DEFAULT"
) (
   input logic        clk,
   input logic        nreset,
   la_orn_pipe_if.slave bus
);

   // Number of radix-4 OR levels needed to reduce N bits to one.
   function automatic int clog4(input int n);
      int r;
      int c;
      r = 0;
      c = 1;
      while (c < n) begin
         c = c * 4;
         r = r + 1;
      end
      return r;
   endfunction

   localparam int L    = clog4(N);
   // Pipeline registers after stage 1: first spread over tree levels, the rest
   // form a plain delay line on the single-bit result.
   localparam int TREG = (STAGES - 1 < L) ? (STAGES - 1) : L;
   localparam int XREG = STAGES - 1 - TREG;

   // The implementation property string has no effect on this RTL.
   if (PROP == "") begin : g_prop_empty
   end

   logic [N-1:0] m;
   logic [N-1:0] hold;
   logic [N-1:0] p1;
   logic         z_tree;
   logic         z_int;
   logic         z_q;

   assign m = bus.in & ~bus.mask;

   // In live mode nothing is kept across cycles; in sticky mode status is kept
   // unless cleared. New events are ORed in after the clear, so set wins.
   assign hold = (STICKY == 0 || bus.clr) ? '0 : p1;

   // Stage 1: live capture of the masked vector, or the sticky status register.
   always_ff @(posedge clk) begin
      if (!nreset)
         p1 <= '0;
      else if (bus.en)
         p1 <= hold | m;
   end

   assign bus.status = (STICKY != 0) ? p1 : '0;

   // Reduction tree. Every level keeps N bits; bits above the live width of a
   // level are always zero, which also pads a partial group of four.
   for (genvar l = 0; l <= L; l++) begin : g_lvl
      logic [N-1:0] out;
      if (l == 0) begin : g_base
         assign out = p1;
      end else begin : g_or
         logic [N-1:0] red;

         // OR each group of four bits of the previous level into one bit.
         always_comb begin
            red = '0;
            for (int i = 0; i < N; i++)
               red[i/4] = red[i/4] | g_lvl[l-1].out[i];
         end

         if (l <= TREG) begin : g_reg
            logic [N-1:0] q;

            // Pipeline register after this tree level.
            always_ff @(posedge clk) begin
               if (!nreset)
                  q <= '0;
               else if (bus.en)
                  q <= red;
            end

            assign out = q;
         end else begin : g_comb
            assign out = red;
         end
      end
   end

   // Only bit 0 of the last level can be set; reducing the whole word is the same value.
   assign z_tree = |g_lvl[L].out;

   if (XREG > 0) begin : g_xtra
      logic [XREG-1:0] dly;

      // Surplus stages once the tree is fully registered: delay the final bit.
      always_ff @(posedge clk) begin
         if (!nreset)
            dly <= '0;
         else if (bus.en) begin
            dly[0] <= z_tree;
            for (int k = 1; k < XREG; k++)
               dly[k] <= dly[k-1];
         end
      end

      assign z_int = dly[XREG-1];
   end else begin : g_noxtra
      assign z_int = z_tree;
   end

   // Previous z for edge detection, advanced only on enabled cycles.
   always_ff @(posedge clk) begin
      if (!nreset)
         z_q <= 1'b0;
      else if (bus.en)
         z_q <= z_int;
   end

   assign bus.z    = z_int;
   // Gated by en so a frozen 0->1 step is reported once, on the first enabled cycle.
   assign bus.rise = bus.en & z_int & ~z_q;

endmodule

// File: tb/tb_la_orn_pipe.sv
// Directed bench for four la_orn_pipe configurations against a latency-queue scoreboard.
// Latency: expected z is pushed per enabled edge and popped STAGES-1 edges later.
// Backpressure: en is driven per instance to freeze the DUT and the model together.
module tb_la_orn_pipe;

   logic clk;
   int   checks;
   int   fails;

   logic [15:0] in_v   [4];
   logic [15:0] mask_v [4];
   logic        en_v   [4];
   logic        clr_v  [4];
   logic        rst_v  [4];

   logic [15:0] st_m   [4];
   bit          z_m    [4];
   bit          zq_m   [4];

   logic        z_obs    [4];
   logic        rise_obs [4];
   logic [15:0] st_obs   [4];

   bit q0[$];
   bit q1[$];
   bit q2[$];
   bit q3[$];

   la_orn_pipe_if #(.N(8))  if0 ();
   la_orn_pipe_if #(.N(6))  if1 ();
   la_orn_pipe_if #(.N(4))  if2 ();
   la_orn_pipe_if #(.N(16)) if3 ();

   la_orn_pipe #(.N(8),  .STAGES(2), .STICKY(0), .PROP("DEFAULT")) u_live   (.clk(clk), .nreset(rst_v[0]), .bus(if0));
   la_orn_pipe #(.N(6),  .STAGES(1), .STICKY(1), .PROP("DEFAULT")) u_sticky (.clk(clk), .nreset(rst_v[1]), .bus(if1));
   la_orn_pipe #(.N(4),  .STAGES(3), .STICKY(0), .PROP("DEFAULT")) u_frz    (.clk(clk), .nreset(rst_v[2]), .bus(if2));
   la_orn_pipe #(.N(16), .STAGES(4), .STICKY(0), .PROP("DEFAULT")) u_rst    (.clk(clk), .nreset(rst_v[3]), .bus(if3));

   assign if0.en = en_v[0];  assign if0.clr = clr_v[0];
   assign if1.en = en_v[1];  assign if1.clr = clr_v[1];
   assign if2.en = en_v[2];  assign if2.clr = clr_v[2];
   assign if3.en = en_v[3];  assign if3.clr = clr_v[3];
   assign if0.in = in_v[0][7:0];  assign if0.mask = mask_v[0][7:0];
   assign if1.in = in_v[1][5:0];  assign if1.mask = mask_v[1][5:0];
   assign if2.in = in_v[2][3:0];  assign if2.mask = mask_v[2][3:0];
   assign if3.in = in_v[3];       assign if3.mask = mask_v[3];

   assign z_obs[0] = if0.z;  assign rise_obs[0] = if0.rise;  assign st_obs[0] = {8'h00, if0.status};
   assign z_obs[1] = if1.z;  assign rise_obs[1] = if1.rise;  assign st_obs[1] = {10'h000, if1.status};
   assign z_obs[2] = if2.z;  assign rise_obs[2] = if2.rise;  assign st_obs[2] = {12'h000, if2.status};
   assign z_obs[3] = if3.z;  assign rise_obs[3] = if3.rise;  assign st_obs[3] = if3.status;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic int stages_of(input int d);
      case (d)
         0: return 2;
         1: return 1;
         2: return 3;
         default: return 4;
      endcase
   endfunction

   function automatic bit sticky_of(input int d);
      return (d == 1);
   endfunction

   function automatic logic [15:0] wmask(input int d);
      case (d)
         0: return 16'h00FF;
         1: return 16'h003F;
         2: return 16'h000F;
         default: return 16'hFFFF;
      endcase
   endfunction

   task automatic q_reset(input int d);
      case (d)
         0: begin q0.delete(); repeat (stages_of(d) - 1) q0.push_back(1'b0); end
         1: begin q1.delete(); repeat (stages_of(d) - 1) q1.push_back(1'b0); end
         2: begin q2.delete(); repeat (stages_of(d) - 1) q2.push_back(1'b0); end
         default: begin q3.delete(); repeat (stages_of(d) - 1) q3.push_back(1'b0); end
      endcase
   endtask

   task automatic q_push_pop(input int d, input bit v, output bit o);
      case (d)
         0: begin q0.push_back(v); o = q0.pop_front(); end
         1: begin q1.push_back(v); o = q1.pop_front(); end
         2: begin q2.push_back(v); o = q2.pop_front(); end
         default: begin q3.push_back(v); o = q3.pop_front(); end
      endcase
   endtask

   task automatic chk(input string tag, input int d, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         fails++;
         $error("FAIL %s dut%0d observed=%h expected=%h", tag, d, obs, exp);
      end
   endtask

   // One clock: advance the model with what is driven, take the edge, compare all instances.
   task automatic tick(input string tag);
      for (int d = 0; d < 4; d++) begin
         logic [15:0] m;
         bit          v;
         bit          nz;
         m = in_v[d] & ~mask_v[d] & wmask(d);
         if (!rst_v[d]) begin
            q_reset(d);
            st_m[d] = 16'h0;
            z_m[d]  = 1'b0;
            zq_m[d] = 1'b0;
         end else if (en_v[d]) begin
            if (sticky_of(d)) begin
               st_m[d] = (clr_v[d] ? 16'h0 : st_m[d]) | m;
               v = |st_m[d];
            end else begin
               v = |m;
            end
            q_push_pop(d, v, nz);
            zq_m[d] = z_m[d];
            z_m[d]  = nz;
         end
      end
      @(posedge clk);
      #1;
      for (int d = 0; d < 4; d++) begin
         chk({tag, "_z"},      d, {15'h0, z_obs[d]},    {15'h0, z_m[d]});
         chk({tag, "_rise"},   d, {15'h0, rise_obs[d]}, {15'h0, en_v[d] & z_m[d] & ~zq_m[d]});
         chk({tag, "_status"}, d, st_obs[d],            st_m[d]);
      end
   endtask

   initial begin
      checks = 0;
      fails  = 0;
      for (int d = 0; d < 4; d++) begin
         in_v[d] = 16'h0; mask_v[d] = 16'h0; en_v[d] = 1'b1; clr_v[d] = 1'b0; rst_v[d] = 1'b0;
         st_m[d] = 16'h0; z_m[d] = 1'b0; zq_m[d] = 1'b0;
      end

      // Reset state
      tick("reset");
      tick("reset");
      for (int d = 0; d < 4; d++) rst_v[d] = 1'b1;
      tick("idle");
      tick("idle");

      // Live mode: single-cycle event appears two edges later, for one cycle
      in_v[0] = 16'h10;  tick("live_in");
      chk("live_early_z", 0, {15'h0, z_obs[0]}, 16'h0);
      in_v[0] = 16'h00;  tick("live");
      chk("live_z_hi", 0, {15'h0, z_obs[0]}, 16'h1);
      chk("live_rise_hi", 0, {15'h0, rise_obs[0]}, 16'h1);
      tick("live");
      chk("live_z_lo", 0, {15'h0, z_obs[0]}, 16'h0);
      tick("live");

      // Masking: blocked bit never reaches z, a second bit does
      mask_v[0] = 16'h10;
      in_v[0] = 16'h10;  tick("mask_in");
      in_v[0] = 16'h00;  tick("mask");  tick("mask");
      chk("mask_blocked_z", 0, {15'h0, z_obs[0]}, 16'h0);
      in_v[0] = 16'h11;  tick("mask_in2");
      in_v[0] = 16'h00;  tick("mask");
      chk("mask_pass_z", 0, {15'h0, z_obs[0]}, 16'h1);
      tick("mask");  tick("mask");
      mask_v[0] = 16'h00;

      // Sticky: event latches until cleared
      in_v[1] = 16'h08;  tick("sticky_in");
      chk("sticky_status", 1, st_obs[1], 16'h0008);
      in_v[1] = 16'h00;  tick("sticky");  tick("sticky");  tick("sticky");
      chk("sticky_hold_z", 1, {15'h0, z_obs[1]}, 16'h1);
      clr_v[1] = 1'b1;   tick("sticky_clr");
      chk("sticky_cleared", 1, st_obs[1], 16'h0000);
      clr_v[1] = 1'b0;   tick("sticky");
      chk("sticky_z_lo", 1, {15'h0, z_obs[1]}, 16'h0);

      // Sticky: set beats clear; an older bit is still cleared
      in_v[1] = 16'h02;  tick("setclr_pre");
      in_v[1] = 16'h01;  clr_v[1] = 1'b1;  tick("setclr");
      chk("setclr_status", 1, st_obs[1], 16'h0001);
      in_v[1] = 16'h00;  clr_v[1] = 1'b0;  tick("setclr");
      chk("setclr_z", 1, {15'h0, z_obs[1]}, 16'h1);

      // Sticky: clr ignored while frozen
      en_v[1] = 1'b0;  clr_v[1] = 1'b1;  tick("frzclr");  tick("frzclr");
      en_v[1] = 1'b1;  clr_v[1] = 1'b0;  tick("frzclr");
      chk("frzclr_status", 1, st_obs[1], 16'h0001);
      clr_v[1] = 1'b1;  tick("sticky_clr2");
      clr_v[1] = 1'b0;  tick("sticky");

      // Enable freeze with an event in flight; inputs during freeze are not captured
      in_v[2] = 16'h1;  tick("frz_in");
      in_v[2] = 16'h0;  en_v[2] = 1'b0;  tick("frz");
      in_v[2] = 16'hF;  tick("frz");  tick("frz");  tick("frz");
      in_v[2] = 16'h0;  tick("frz");
      chk("frz_z_held", 2, {15'h0, z_obs[2]}, 16'h0);
      en_v[2] = 1'b1;  tick("frz_resume");
      chk("frz_resume_z", 2, {15'h0, z_obs[2]}, 16'h0);
      tick("frz_resume");
      chk("frz_arrive_z", 2, {15'h0, z_obs[2]}, 16'h1);
      chk("frz_arrive_rise", 2, {15'h0, rise_obs[2]}, 16'h1);
      tick("frz_after");  tick("frz_after");

      // Freeze while the pulse is high: rise drops, no second pulse later
      in_v[2] = 16'h2;  tick("frz2_in");
      in_v[2] = 16'h0;  tick("frz2");  tick("frz2");
      en_v[2] = 1'b0;   tick("frz2_hold");  tick("frz2_hold");
      chk("frz2_rise_lo", 2, {15'h0, rise_obs[2]}, 16'h0);
      en_v[2] = 1'b1;   tick("frz2_resume");  tick("frz2_resume");

      // Reset mid-flight discards the pending event; reset overrides en
      in_v[3] = 16'h8000;  tick("rst_in");
      in_v[3] = 16'h0000;  tick("rst_flight");
      rst_v[3] = 1'b0;  en_v[3] = 1'b0;  tick("rst_edge");
      chk("rst_z", 3, {15'h0, z_obs[3]}, 16'h0);
      rst_v[3] = 1'b1;  en_v[3] = 1'b1;
      for (int k = 0; k < 6; k++) tick("rst_drain");
      chk("rst_drained_z", 3, {15'h0, z_obs[3]}, 16'h0);

      // Clean pass through the 4-stage, 2-level instance
      in_v[3] = 16'h8000;  tick("deep_in");
      in_v[3] = 16'h0000;  tick("deep");  tick("deep");  tick("deep");
      chk("deep_z", 3, {15'h0, z_obs[3]}, 16'h1);
      chk("deep_rise", 3, {15'h0, rise_obs[3]}, 16'h1);
      tick("deep");  tick("deep");

      $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
      $finish;
   end

endmodule
